// File: rtl/sd_card_dat_responder.sv
// sd_card_dat_responder: card-side engine for the SD DAT0 line.
// Reads transmit framed blocks: start bit, payload, CRC16, end bit.
// Writes receive framed blocks, answer with a CRC status token, then hold busy.
// Optional feature: define SD_CARD_DAT_CRC16_EN to generate and check a real CRC16.
// Without it the read CRC field is all ones and write checks look at the end bit only.
module sd_card_dat_responder #(
  parameter int BLOCK_BITS  = 32,
  parameter int NAC_CYCLES  = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int BUSY_CYCLES = 8
) (
  input  logic                  sd_clock,
  input  logic                  reset,
  input  logic                  start_read,
  input  logic                  start_write,
  input  logic                  stop,
  input  logic [3:0]            block_count,
  input  logic [BLOCK_BITS-1:0] data_in,
  output logic                  data_req,
  output logic [BLOCK_BITS-1:0] data_out,
  output logic                  data_valid,
  output logic                  crc_ok,
  input  logic                  dat_in,
  output logic                  dat_out,
  output logic                  dat_oe,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [4:0] {
    IDLE, RD_WAIT, RD_START, RD_DATA, RD_CRC, RD_END, RD_GAP,
    WR_WAIT, WR_DATA, WR_CRC, WR_END, WR_RESULT, WR_NCRC,
    WR_STATUS, WR_BUSY, WR_RELEASE, DONE
  } state_t;

  localparam logic [15:0] NAC_LAST   = 16'(NAC_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] DATA_LAST  = 16'(BLOCK_BITS - 1);
  localparam logic [15:0] BUSY_LAST  = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] CRC_LAST   = 16'd15;
  localparam logic [15:0] NCRC_LAST  = 16'd1;
  localparam logic [15:0] TOKEN_LAST = 16'd4;

  state_t                  state_reg;
  state_t                  state_next;
  logic [15:0]             cnt_reg;
  logic [3:0]              blocks_reg;
  logic [BLOCK_BITS-1:0]   tx_shift_reg;
  logic [BLOCK_BITS-1:0]   rx_shift_reg;
  logic                    load_tx;
  logic                    last_block;
  logic                    crc_match;
  logic                    rd_crc_bit;
  logic [4:0]              token;
  logic [2:0]              token_idx;

  // A new read payload is taken on the last Nac cycle and on the last inter-block gap cycle
  assign load_tx    = ((state_reg == RD_WAIT) && (cnt_reg == NAC_LAST)) ||
                      ((state_reg == RD_GAP)  && (cnt_reg == GAP_LAST));
  assign last_block = (blocks_reg <= 4'd1);

`ifdef SD_CARD_DAT_CRC16_EN
  logic [15:0] crc_reg;
  logic [15:0] rx_crc_reg;

  // One serial step of x^16+x^12+x^5+1
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // CRC accumulator: cleared at block start, fed with data bits, shifted out on reads
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      crc_reg    <= '0;
      rx_crc_reg <= '0;
    end else begin
      case (state_reg)
        RD_WAIT, RD_GAP: if (load_tx) crc_reg <= '0;
        RD_DATA:         crc_reg <= crc16_step(crc_reg, tx_shift_reg[BLOCK_BITS-1]);
        RD_CRC:          crc_reg <= {crc_reg[14:0], 1'b0};
        WR_WAIT:         if (!dat_in) crc_reg <= '0;
        WR_DATA:         crc_reg <= crc16_step(crc_reg, dat_in);
        WR_CRC:          rx_crc_reg <= {rx_crc_reg[14:0], dat_in};
        default:         ;
      endcase
    end
  end

  assign crc_match  = (crc_reg == rx_crc_reg);
  assign rd_crc_bit = crc_reg[15];
`else
  assign crc_match  = 1'b1;
  assign rd_crc_bit = 1'b1;
`endif

  // State register
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; stop overrides everything
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_read)       state_next = RD_WAIT;
        else if (start_write) state_next = WR_WAIT;
      end
      RD_WAIT:    if (cnt_reg == NAC_LAST)   state_next = RD_START;
      RD_START:   state_next = RD_DATA;
      RD_DATA:    if (cnt_reg == DATA_LAST)  state_next = RD_CRC;
      RD_CRC:     if (cnt_reg == CRC_LAST)   state_next = RD_END;
      RD_END:     state_next = last_block ? DONE : RD_GAP;
      RD_GAP:     if (cnt_reg == GAP_LAST)   state_next = RD_START;
      WR_WAIT:    if (!dat_in)               state_next = WR_DATA;
      WR_DATA:    if (cnt_reg == DATA_LAST)  state_next = WR_CRC;
      WR_CRC:     if (cnt_reg == CRC_LAST)   state_next = WR_END;
      WR_END:     state_next = WR_RESULT;
      WR_RESULT:  state_next = WR_NCRC;
      WR_NCRC:    if (cnt_reg == NCRC_LAST)  state_next = WR_STATUS;
      WR_STATUS:  if (cnt_reg == TOKEN_LAST) state_next = WR_BUSY;
      WR_BUSY:    if (cnt_reg == BUSY_LAST)  state_next = WR_RELEASE;
      WR_RELEASE: state_next = last_block ? DONE : WR_WAIT;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    if (stop) state_next = IDLE;
  end

  // Moore outputs: pad drive, handshakes and status pulses
  always_comb begin
    dat_oe     = 1'b0;
    dat_out    = 1'b1;
    data_req   = load_tx;
    done       = 1'b0;
    data_valid = 1'b0;
    busy       = (state_reg != IDLE);
    token      = crc_ok ? 5'b00101 : 5'b01011;
    token_idx  = 3'd4 - cnt_reg[2:0];
    case (state_reg)
      RD_WAIT:    dat_oe = 1'b1;
      RD_START:   begin dat_oe = 1'b1; dat_out = 1'b0; end
      RD_DATA:    begin dat_oe = 1'b1; dat_out = tx_shift_reg[BLOCK_BITS-1]; end
      RD_CRC:     begin dat_oe = 1'b1; dat_out = rd_crc_bit; end
      RD_END:     dat_oe = 1'b1;
      RD_GAP:     dat_oe = 1'b1;
      WR_RESULT:  data_valid = 1'b1;
      WR_STATUS:  begin dat_oe = 1'b1; dat_out = token[token_idx]; end
      WR_BUSY:    begin dat_oe = 1'b1; dat_out = 1'b0; end
      WR_RELEASE: dat_oe = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Datapath: phase counter, block count, shifters and the received-block result
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      cnt_reg      <= '0;
      blocks_reg   <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      data_out     <= '0;
      crc_ok       <= 1'b0;
    end else begin
      if (state_next != state_reg) cnt_reg <= '0;
      else                         cnt_reg <= cnt_reg + 16'd1;
      if (load_tx) tx_shift_reg <= data_in;
      case (state_reg)
        IDLE: begin
          if (start_read || start_write)
            blocks_reg <= (block_count == 4'd0) ? 4'd1 : block_count;
        end
        RD_DATA:            tx_shift_reg <= {tx_shift_reg[BLOCK_BITS-2:0], 1'b0};
        RD_END, WR_RELEASE: if (!last_block) blocks_reg <= blocks_reg - 4'd1;
        WR_DATA:            rx_shift_reg <= {rx_shift_reg[BLOCK_BITS-2:0], dat_in};
        WR_END: begin
          if (!stop) begin
            data_out <= rx_shift_reg;
            crc_ok   <= crc_match && dat_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
